// File: rtl/audio_pkg.sv
// Shared definitions for the serial-audio receive path: receiver states,
// framing-mode constants and the bit-counter width helper.
package audio_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } rx_state_t;

   localparam int MODE_I2S = 0;
   localparam int MODE_TDM = 1;

   // Width of the in-slot bit counter; never narrower than one bit.
   function automatic int bit_idx_width(input int slot_width);
      return (slot_width > 1) ? $clog2(slot_width) : 1;
   endfunction

endpackage

// File: rtl/ws_sync_detect.sv
// Word-select edge detector. Produces the sync strobe for the selected
// framing mode and, for I2S, the channel announced by the new ws level.
module ws_sync_detect
   import audio_pkg::*;
#(
   parameter int MODE = MODE_I2S
) (
   input  logic sclk_i,
   input  logic rst_i,
   input  logic ws_i,
   output logic sync,
   output logic sync_ch
);

   logic ws_prev;

   // Keep the previously sampled ws level for edge detection.
   always_ff @(posedge sclk_i or posedge rst_i) begin
      if (rst_i) ws_prev <= 1'b0;
      else       ws_prev <= ws_i;
   end

   // I2S syncs on either ws edge (level picks the channel); TDM on rising only.
   always_comb begin
      sync    = 1'b0;
      sync_ch = 1'b0;
      if (MODE == MODE_TDM) begin
         sync = ws_i & ~ws_prev;
      end else begin
         sync    = ws_i ^ ws_prev;
         sync_ch = ws_i;
      end
   end

endmodule

// File: rtl/i2s_rx_multi.sv
// Multi-channel I2S/TDM serial-audio receiver with framing-error detection
// and automatic resynchronisation. Whole frames are published on chan_o with
// a one-cycle valid_o strobe. Optional saturating error counter enabled by
// defining I2S_RX_ERRCNT_EN; otherwise errCnt_o is tied to zero.
module i2s_rx_multi
   import audio_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SLOT_WIDTH = 16,
   parameter int NUM_CH     = 2,
   parameter int MODE       = MODE_I2S
) (
   input  logic                    sclk_i,
   input  logic                    rst_i,
   input  logic                    ws_i,
   input  logic                    sdata_i,
   output logic [NUM_CH*WIDTH-1:0] chan_o,
   output logic                    valid_o,
   output logic                    frameErr_o,
   output logic [7:0]              errCnt_o
);

   localparam int BW = bit_idx_width(SLOT_WIDTH);
   localparam int CW = $clog2(NUM_CH);
   localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_WIDTH - 1);
   localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
   localparam logic [BW:0]   DATA_BITS = (BW + 1)'(WIDTH);

   if (SLOT_WIDTH < WIDTH) begin : g_bad_slot
      $error("i2s_rx_multi: SLOT_WIDTH must be >= WIDTH");
   end
   if ((MODE == MODE_I2S && NUM_CH != 2) ||
       (MODE == MODE_TDM && (NUM_CH < 2 || NUM_CH > 16))) begin : g_bad_ch
      $error("i2s_rx_multi: NUM_CH not supported for this MODE");
   end

   rx_state_t               state_q, state_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [CW-1:0]           ch_q, ch_d;
   logic                    full_q, full_d;   // frame received from channel 0 onward
   logic [WIDTH-1:0]        sh_q [NUM_CH];
   logic [WIDTH-1:0]        sh_d [NUM_CH];
   logic [NUM_CH*WIDTH-1:0] frame_d;
   logic                    publish, err, expect_sync;
   logic                    sync, sync_ch;
   logic [CW-1:0]           sync_ch_idx;

   ws_sync_detect #(.MODE(MODE)) u_sync (
      .sclk_i  (sclk_i),
      .rst_i   (rst_i),
      .ws_i    (ws_i),
      .sync    (sync),
      .sync_ch (sync_ch)
   );

   assign sync_ch_idx = CW'(sync_ch);

   // Next-state decode: hunt for sync, receive slots, flag framing errors.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      ch_d        = ch_q;
      full_d      = full_q;
      sh_d        = sh_q;
      publish     = 1'b0;
      err         = 1'b0;
      expect_sync = (bit_q == LAST_BIT) && ((MODE == MODE_I2S) || (ch_q == LAST_CH));
      unique case (state_q)
         HUNT: begin
            if (sync) begin
               state_d = RECV;
               bit_d   = '0;
               ch_d    = sync_ch_idx;
               full_d  = (sync_ch_idx == '0);
            end
         end
         RECV: begin
            if (sync != expect_sync) begin
               // Partial frame is abandoned; an unexpected sync is a valid new start.
               err = 1'b1;
               if (sync) begin
                  bit_d  = '0;
                  ch_d   = sync_ch_idx;
                  full_d = (sync_ch_idx == '0);
               end else begin
                  state_d = HUNT;
               end
            end else begin
               if ({1'b0, bit_q} < DATA_BITS)
                  sh_d[ch_q] = (sh_q[ch_q] << 1) | WIDTH'(sdata_i);
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (ch_q == LAST_CH) begin
                     ch_d    = '0;
                     full_d  = 1'b1;
                     publish = full_q;
                  end else begin
                     ch_d = ch_q + CW'(1);
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
      endcase
   end

   // Flatten the shift registers (including this edge's bit) for publishing.
   always_comb begin
      frame_d = '0;
      for (int k = 0; k < NUM_CH; k++) frame_d[k*WIDTH +: WIDTH] = sh_d[k];
   end

   // Control state and registered outputs.
   // NOTE: sequential state uses non-blocking assignments; the decode above is blocking.
   always_ff @(posedge sclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= HUNT;
         bit_q      <= '0;
         ch_q       <= '0;
         full_q     <= 1'b0;
         chan_o     <= '0;
         valid_o    <= 1'b0;
         frameErr_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         ch_q       <= ch_d;
         full_q     <= full_d;
         valid_o    <= publish;
         frameErr_o <= err;
         if (publish) chan_o <= frame_d;
      end
   end

   // Channel shift registers.
   // NOTE: no reset here; every slot is fully rewritten before a frame can publish.
   always_ff @(posedge sclk_i) begin
      sh_q <= sh_d;
   end

`ifdef I2S_RX_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of framing errors, updated with frameErr_o.
   always_ff @(posedge sclk_i or posedge rst_i) begin
      if (rst_i)                           err_cnt_q <= '0;
      else if (err && err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign errCnt_o = err_cnt_q;
`else
   assign errCnt_o = 8'd0;
`endif

endmodule
